// File: rtl/turn_pkg.sv
// Shared state codes and 60 MHz timing defaults for the turn sequencer.
package turn_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE       = 3'd0;
    localparam state_t WAIT_THROW = 3'd1;
    localparam state_t IN_FLIGHT  = 3'd2;
    localparam state_t SETTLE     = 3'd3;
    localparam state_t DONE       = 3'd4;

    // Settle debounce in cycles; timeout is 5 s at 60 MHz.
    localparam int SETTLE_DEFAULT  = 4;
    localparam int TIMEOUT_DEFAULT = 300_000_000;

endpackage

// File: rtl/turn_sequencer_if.sv
// Throw inputs and turn/status outputs between game logic and the sequencer.
interface turn_sequencer_if #(
    parameter int TURN_W   = 3,
    parameter int PLAYER_W = 1,
    parameter int ROUND_W  = 4
);
    logic                start_game;
    logic                throw_flag;
    logic                in_throw_flag;
    logic [TURN_W-1:0]   turn;
    logic [PLAYER_W-1:0] active_player;
    logic [ROUND_W-1:0]  round;
    logic                game_over;
    logic                throw_active;
    logic                turn_advance;
    logic                timeout;

    modport master (
        output start_game, throw_flag, in_throw_flag,
        input  turn, active_player, round,
        input  game_over, throw_active, turn_advance, timeout
    );

    modport slave (
        input  start_game, throw_flag, in_throw_flag,
        output turn, active_player, round,
        output game_over, throw_active, turn_advance, timeout
    );
endinterface

// File: rtl/turn_timer.sv
// Clearable up-counter with terminal-count compare; shared by settle and timeout.
module turn_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)   count <= '0;
        else if (clr) count <= '0;
        else if (en)  count <= count + W'(1);
    end

    assign tc = (count == limit);
endmodule

// File: rtl/turn_sequencer.sv
// N-player turn controller: debounced throw end, timeout advance, round limit.
module turn_sequencer
    import turn_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int MAX_ROUNDS     = 8,
    parameter int TURN_W         = 3,
    parameter int SETTLE_CYCLES  = SETTLE_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic             clk60MHz,
    input  logic             rst_n,
    turn_sequencer_if.slave  bus
);
    localparam int PLAYER_W = ($clog2(NUM_PLAYERS) < 1) ? 1 : $clog2(NUM_PLAYERS);
    localparam int ROUND_W  = $clog2(MAX_ROUNDS + 1);
    localparam int TMR_MAX  = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int TO_LIM   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit TO_EN    = (TIMEOUT_CYCLES != 0);

    state_t              state;
    logic [TURN_W-1:0]   turn_q;
    logic [PLAYER_W-1:0] player_q;
    logic [ROUND_W-1:0]  round_q;
    logic                over_q;
    logic                active_q;
    logic                adv_q;
    logic                to_q;

    logic               any;
    logic               wrap;
    logic [ROUND_W-1:0] round_nx;
    logic               last;
    logic               tc;
    logic               expire;
    logic               settled;
    logic               adv;
    logic               fly;
    logic               land;
    logic               tmr_clr;
    logic               tmr_en;
    logic [TMR_W-1:0]   limit;

    assign any      = bus.throw_flag | bus.in_throw_flag;
    assign wrap     = (player_q == PLAYER_W'(NUM_PLAYERS - 1));
    assign round_nx = wrap ? round_q + ROUND_W'(1) : round_q;
    assign last     = wrap && (round_nx == ROUND_W'(MAX_ROUNDS));

    // A flag in the expiry cycle beats the timeout.
    assign expire  = TO_EN && (state == WAIT_THROW) && !any && tc;
    assign settled = (state == SETTLE) && !any && tc;
    assign adv     = expire | settled;
    assign fly     = any && ((state == WAIT_THROW) || (state == SETTLE));
    assign land    = (state == IN_FLIGHT) && !any;

    assign limit   = (state == SETTLE) ? TMR_W'(SETTLE_CYCLES - 1) : TMR_W'(TO_LIM);
    assign tmr_en  = (state == SETTLE) || (TO_EN && (state == WAIT_THROW));
    assign tmr_clr = bus.start_game | any | adv | !tmr_en;

    turn_timer #(.W(TMR_W)) u_timer (
        .clk   (clk60MHz),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (limit),
        .tc    (tc)
    );

    always_ff @(posedge clk60MHz) begin
        if (!rst_n || bus.start_game) begin
            state    <= rst_n ? WAIT_THROW : IDLE;
            turn_q   <= TURN_W'(1);
            player_q <= '0;
            round_q  <= '0;
            over_q   <= 1'b0;
            active_q <= 1'b0;
            adv_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            adv_q <= adv;
            to_q  <= expire;
            unique case (1'b1)
                adv: begin
                    turn_q   <= turn_q + TURN_W'(1);
                    player_q <= wrap ? '0 : player_q + PLAYER_W'(1);
                    round_q  <= round_nx;
                    state    <= last ? DONE : WAIT_THROW;
                    over_q   <= last;
                    active_q <= 1'b0;
                end
                fly: begin
                    state    <= IN_FLIGHT;
                    active_q <= 1'b1;
                end
                land: state <= SETTLE;
                default: ;
            endcase
        end
    end

    assign bus.turn          = turn_q;
    assign bus.active_player = player_q;
    assign bus.round         = round_q;
    assign bus.game_over     = over_q;
    assign bus.throw_active  = active_q;
    assign bus.turn_advance  = adv_q;
    assign bus.timeout       = to_q;
endmodule
